// File: rtl/crc_input_buffer.sv
// crc_input_buffer
// ----------------
// Sits between the CRC AHB host interface and the byte-wide CRC engine.
// CRC_DR writes are pushed into a small FIFO of 32-bit words, and the
// configured input bit-reversal is applied as each word is pushed. The head
// entry is then handed to the engine one byte at a time, lane 0 first. The
// block also produces the back-pressure flags that the host uses to stall
// HREADYOUT, and turns a reset_chain request into one crc_chain_rst pulse.
// That pulse is held back until every queued byte has been processed.
//
// Ports
//   HCLK, HRESETn      clock and asynchronous active-low reset
//   bus_wr[31:0]       CRC_DR write data
//   bus_size[1:0]      0 byte, 1 halfword, 2/3 word
//   buffer_write_en    push request
//   rev_in_type[1:0]   0 none, 1 per byte, 2 per halfword, 3 whole word
//   reset_chain        request to reload the CRC init value
//   crc_busy           engine still working on the last accepted byte
//   byte_ready         engine takes data_byte this cycle
//   data_byte[7:0]     byte to the engine, with byte_valid and byte_last
//   buffer_full/empty  FIFO occupancy flags
//   read_wait          CRC_DR read must stall
//   reset_pending      reset_chain accepted but not yet applied
//   crc_chain_rst      one-cycle reload pulse to the engine
//
// Handshake: a byte transfers on a rising HCLK edge where byte_valid and
// byte_ready are both high. data_byte, byte_valid and byte_last hold steady
// while byte_ready is low. The producer side does not handshake: a push
// offered while buffer_full is high is dropped. The host avoids this by
// stalling the bus.
module crc_input_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] bus_wr,
  input  logic [1:0]  bus_size,
  input  logic        buffer_write_en,
  input  logic [1:0]  rev_in_type,
  input  logic        reset_chain,
  input  logic        crc_busy,
  input  logic        byte_ready,
  output logic [7:0]  data_byte,
  output logic        byte_valid,
  output logic        byte_last,
  output logic        buffer_full,
  output logic        buffer_empty,
  output logic        read_wait,
  output logic        reset_pending,
  output logic        crc_chain_rst
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Entry layout: {nbytes[2:0], word[31:0]}
  logic [34:0]      mem_q [DEPTH];
  logic [34:0]      mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic             pending_q, pending_d;

  logic [34:0] head;
  logic [2:0]  head_n;
  logic [2:0]  push_n;
  logic [31:0] push_word;
  logic        push, pop, fire;

  function automatic logic [31:0] reverse_in(input logic [31:0] d, input logic [1:0] t);
    logic [31:0] r;
    r = d;
    for (int i = 0; i < 32; i++) begin
      case (t)
        2'd1:    r[i] = d[(i / 8) * 8 + 7 - (i % 8)];
        2'd2:    r[i] = d[(i / 16) * 16 + 15 - (i % 16)];
        2'd3:    r[i] = d[31 - i];
        default: r[i] = d[i];
      endcase
    end
    return r;
  endfunction

  always_comb begin
    head         = mem_q[rptr_q];
    head_n       = head[34:32];
    buffer_full  = (count_q == CNT_W'(DEPTH));
    buffer_empty = (count_q == '0);
    byte_valid   = !buffer_empty;
    // Gated so an empty FIFO never shows stale data from a popped entry.
    data_byte    = buffer_empty ? 8'h00 : head[{byte_idx_q, 3'b000} +: 8];
    byte_last    = !buffer_empty && ({1'b0, byte_idx_q} == head_n - 3'd1);
    read_wait    = !buffer_empty || crc_busy;
    reset_pending = pending_q;
    fire          = pending_q && buffer_empty && !crc_busy;
    crc_chain_rst = fire;

    case (bus_size)
      2'd0:    push_n = 3'd1;
      2'd1:    push_n = 3'd2;
      default: push_n = 3'd4;
    endcase
    push_word = reverse_in(bus_wr, rev_in_type);

    // A push that arrives while full is dropped, even if a pop happens in
    // the same cycle.
    push = buffer_write_en && !buffer_full;
    pop  = byte_valid && byte_ready && byte_last;

    mem_d = mem_q;
    if (push) mem_d[wptr_q] = {push_n, push_word};

    wptr_d = push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + PTR_W'(1) : rptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    byte_idx_d = byte_idx_q;
    if (byte_valid && byte_ready) byte_idx_d = byte_last ? 2'd0 : byte_idx_q + 2'd1;

    // A repeated request while one is pending merges into it, and a request
    // in the same cycle as the pulse is absorbed by that pulse.
    pending_d = (pending_q || reset_chain) && !fire;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      byte_idx_q <= '0;
      pending_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      byte_idx_q <= byte_idx_d;
      pending_q  <= pending_d;
    end
  end

endmodule
